// File: rtl/_rf_wr_sched.sv
// Write-port scheduler for the 32-entry register file.
// Arbitrates the ALU (A) and load (B) writeback paths onto one registered
// write port and produces the one-hot write select alongside the address.
// Optional build macro: RF_SCRUB_EN. When it is defined, a post-reset scrub
// writes zero to registers 1..31 before any requester is served.
module _rf_wr_sched #(
    parameter int XLEN = 32,
    parameter bit FAIR = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_addr,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [XLEN-1:0] wr_data,
    output logic [31:0]     wr_sel,
    output logic            busy
);

    logic            run;         // requesters may be granted this cycle
    logic            scrub_wr;    // scrub owns the write port this cycle
    logic [4:0]      scrub_addr;  // register being scrubbed

    logic            prio_b_q, prio_b_d;  // 1: B wins the next tie
    logic            acc_a, acc_b;

    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [31:0]     wr_sel_q, wr_sel_d;

`ifdef RF_SCRUB_EN
    typedef enum logic {SCRUB, RUN} state_t;

    state_t   state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    // State and scrub counter register; reset restarts the scrub at x1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCRUB;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: one scrub write per cycle, leave after register 31.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        scrub_wr = 1'b0;
        run      = 1'b0;
        case (state_q)
            SCRUB: begin
                scrub_wr = 1'b1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign scrub_addr = cnt_q;
    assign busy       = (state_q == SCRUB);
`else
    assign run        = 1'b1;
    assign scrub_wr   = 1'b0;
    assign scrub_addr = 5'd0;
    assign busy       = 1'b0;
`endif

    // Grant: single requester always wins; ties go round-robin or to A.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (run) begin
            if (a_valid && b_valid) begin
                if (FAIR && prio_b_q) begin
                    b_ready = 1'b1;
                end else begin
                    a_ready = 1'b1;
                end
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
        end
    end

    assign acc_a = a_valid && a_ready;
    assign acc_b = b_valid && b_ready;

    // Priority pointer moves only on an accepted grant.
    always_comb begin
        prio_b_d = prio_b_q;
        if (acc_a) begin
            prio_b_d = 1'b1;
        end else if (acc_b) begin
            prio_b_d = 1'b0;
        end
    end

    // Round-robin pointer register; reset gives A priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

    // Write-port next state; x0 writes load addr/data but never strobe.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_sel_d  = 32'd0;
        if (scrub_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = scrub_addr;
            wr_data_d = '0;
            wr_sel_d  = 32'd1 << scrub_addr;
        end else if (acc_a) begin
            wr_en_d   = (a_addr != 5'd0);
            wr_addr_d = a_addr;
            wr_data_d = a_data;
            wr_sel_d  = (a_addr != 5'd0) ? (32'd1 << a_addr) : 32'd0;
        end else if (acc_b) begin
            wr_en_d   = (b_addr != 5'd0);
            wr_addr_d = b_addr;
            wr_data_d = b_data;
            wr_sel_d  = (b_addr != 5'd0) ? (32'd1 << b_addr) : 32'd0;
        end
    end

    // Output registers; select is registered with the address, not decoded after.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= '0;
            wr_sel_q  <= 32'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_sel_q  <= wr_sel_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_sel  = wr_sel_q;

endmodule

// File: tb/tb__rf_wr_sched.sv
// Bench for _rf_wr_sched: a round-robin instance (f_*) and a fixed-priority
// instance (p_*) share all inputs and are checked against a reference model.
module tb__rf_wr_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_addr = 5'd0, b_addr = 5'd0;
    logic [31:0] a_data = 32'd0, b_data = 32'd0;

    logic        f_a_ready, f_b_ready, f_wr_en, f_busy;
    logic [4:0]  f_wr_addr;
    logic [31:0] f_wr_data, f_wr_sel;
    logic        p_a_ready, p_b_ready, p_wr_en, p_busy;
    logic [4:0]  p_wr_addr;
    logic [31:0] p_wr_data, p_wr_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    _rf_wr_sched #(.XLEN(32), .FAIR(1'b1)) dut_f (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(f_a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(f_b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(f_wr_en), .wr_addr(f_wr_addr), .wr_data(f_wr_data), .wr_sel(f_wr_sel),
        .busy(f_busy)
    );

    _rf_wr_sched #(.XLEN(32), .FAIR(1'b0)) dut_p (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(p_a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(p_b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data), .wr_sel(p_wr_sel),
        .busy(p_busy)
    );

    // ---------------- reference model (index 0 = fair, 1 = fixed) ----------
    int          m_scrub = 32;   // next register to scrub; 32 = no scrub left
    int          m_last[2];      // 1 when A was the most recent grant
    bit          m_ga[2], m_gb[2], m_en[2];
    bit          m_busy;
    logic [4:0]  m_addr[2];
    logic [31:0] m_data[2], m_sel[2];

    function automatic logic [31:0] onehot(input logic [4:0] n);
        logic [31:0] s;
        s    = 32'd0;
        s[n] = 1'b1;
        return s;
    endfunction

    task automatic model_eval();
        m_busy = (m_scrub <= 31);
        for (int k = 0; k < 2; k++) begin
            m_ga[k] = 1'b0;
            m_gb[k] = 1'b0;
            if (!m_busy) begin
                if (a_valid && b_valid) begin
                    if (k == 0 && m_last[0] == 1) m_gb[k] = 1'b1;
                    else                          m_ga[k] = 1'b1;
                end else begin
                    m_ga[k] = a_valid;
                    m_gb[k] = b_valid;
                end
            end
        end
    endtask

    task automatic model_commit();
        model_eval();
        if (rst) begin
`ifdef RF_SCRUB_EN
            m_scrub = 1;
`else
            m_scrub = 32;
`endif
            for (int k = 0; k < 2; k++) begin
                m_last[k] = 0; m_en[k] = 1'b0; m_addr[k] = 5'd0;
                m_data[k] = 32'd0; m_sel[k] = 32'd0;
            end
        end else if (m_scrub <= 31) begin
            for (int k = 0; k < 2; k++) begin
                m_en[k] = 1'b1; m_addr[k] = 5'(m_scrub);
                m_data[k] = 32'd0; m_sel[k] = onehot(5'(m_scrub));
            end
            m_scrub++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_ga[k]) begin
                    m_addr[k] = a_addr; m_data[k] = a_data; m_last[k] = 1;
                end else if (m_gb[k]) begin
                    m_addr[k] = b_addr; m_data[k] = b_data; m_last[k] = 0;
                end
                m_en[k] = (m_ga[k] || m_gb[k]) && (m_addr[k] != 5'd0);
                m_sel[k] = m_en[k] ? onehot(m_addr[k]) : 32'd0;
            end
        end
    endtask

    // ---------------- stimulus helpers (no comparisons) --------------------
    task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                          input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        model_eval();
    endtask

    // Edge, model update, then settle to posedge+1.
    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance();
        advance();
        rst = 1'b0;
        model_eval();
`ifdef RF_SCRUB_EN
        repeat (31) advance();
`endif
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        logic exp_busy;
`ifdef RF_SCRUB_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        rst = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance();
        advance();
        total++;
        if ({f_wr_en, f_wr_addr, f_wr_data, f_wr_sel} !== 70'd0) begin
            bad++; $display("FAIL reset_out_fair got=%h exp=0", {f_wr_en, f_wr_addr, f_wr_data, f_wr_sel});
        end
        total++;
        if ({p_wr_en, p_wr_addr, p_wr_data, p_wr_sel} !== 70'd0) begin
            bad++; $display("FAIL reset_out_fixed got=%h exp=0", {p_wr_en, p_wr_addr, p_wr_data, p_wr_sel});
        end
        total++;
        if (f_busy !== exp_busy || p_busy !== exp_busy) begin
            bad++; $display("FAIL reset_busy got=%b%b exp=%b", f_busy, p_busy, exp_busy);
        end
        rst = 1'b0;
        model_eval();
`ifdef RF_SCRUB_EN
        repeat (31) advance();
`endif
    endtask

`ifdef RF_SCRUB_EN
    task automatic test_scrub();
        rst = 1'b1;
        set_in(1'b1, 5'd7, 32'hCAFE0007, 1'b0, 5'd0, 32'd0);
        advance();
        rst = 1'b0;
        model_eval();
        for (int c = 0; c < 32; c++) begin
            #2;
            total++;
            if (c < 31) begin
                if (f_busy !== 1'b1 || f_a_ready !== 1'b0) begin
                    bad++; $display("FAIL scrub_busy c=%0d got busy=%b rdy=%b exp busy=1 rdy=0", c, f_busy, f_a_ready);
                end
            end else begin
                if (f_busy !== 1'b0 || f_a_ready !== 1'b1) begin
                    bad++; $display("FAIL scrub_done c=%0d got busy=%b rdy=%b exp busy=0 rdy=1", c, f_busy, f_a_ready);
                end
            end
            advance();
            total++;
            if (c < 31) begin
                if ({f_wr_en, f_wr_addr, f_wr_data, f_wr_sel} !== {1'b1, 5'(c + 1), 32'd0, onehot(5'(c + 1))}) begin
                    bad++; $display("FAIL scrub_write c=%0d got en=%b addr=%0d data=%h sel=%h exp addr=%0d",
                                    c, f_wr_en, f_wr_addr, f_wr_data, f_wr_sel, c + 1);
                end
            end else begin
                if (f_wr_en !== 1'b1 || f_wr_addr !== 5'd7 || f_wr_data !== 32'hCAFE0007) begin
                    bad++; $display("FAIL scrub_first_accept got en=%b addr=%0d data=%h exp en=1 addr=7 data=cafe0007",
                                    f_wr_en, f_wr_addr, f_wr_data);
                end
            end
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance();
    endtask
`endif

    task automatic test_single_a();
        do_reset();
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        #2;
        total++;
        if (f_a_ready !== 1'b1 || f_b_ready !== 1'b0 || p_a_ready !== 1'b1) begin
            bad++; $display("FAIL single_a_ready got=%b%b%b exp=101", f_a_ready, f_b_ready, p_a_ready);
        end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if ({f_wr_en, f_wr_addr, f_wr_data, f_wr_sel} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h00000020}) begin
            bad++; $display("FAIL single_a_write got en=%b addr=%0d data=%h sel=%h exp en=1 addr=5 data=deadbeef sel=00000020",
                            f_wr_en, f_wr_addr, f_wr_data, f_wr_sel);
        end
        advance();
        total++;
        if (f_wr_en !== 1'b0 || f_wr_sel !== 32'd0 || f_wr_addr !== 5'd5 || f_wr_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL idle_hold got en=%b sel=%h addr=%0d data=%h exp en=0 sel=0 addr=5 data=deadbeef",
                            f_wr_en, f_wr_sel, f_wr_addr, f_wr_data);
        end
    endtask

    task automatic test_fair_alternate();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'd9, 32'hA0 + 32'(i), 1'b1, 5'd17, 32'hB0 + 32'(i));
            #2;
            total++;
            if (f_a_ready !== (i % 2 == 0) || f_b_ready !== (i % 2 == 1) || (f_a_ready && f_b_ready)) begin
                bad++; $display("FAIL fair_grant i=%0d got a=%b b=%b exp a=%b b=%b",
                                i, f_a_ready, f_b_ready, (i % 2 == 0), (i % 2 == 1));
            end
            advance();
            total++;
            if (f_wr_en !== 1'b1 || f_wr_addr !== ((i % 2 == 0) ? 5'd9 : 5'd17)) begin
                bad++; $display("FAIL fair_write i=%0d got en=%b addr=%0d exp en=1 addr=%0d",
                                i, f_wr_en, f_wr_addr, (i % 2 == 0) ? 9 : 17);
            end
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'd3, 32'h300 + 32'(i), 1'b1, 5'd4, 32'h400 + 32'(i));
            #2;
            total++;
            if (p_a_ready !== 1'b1 || p_b_ready !== 1'b0) begin
                bad++; $display("FAIL fixed_grant i=%0d got a=%b b=%b exp a=1 b=0", i, p_a_ready, p_b_ready);
            end
            advance();
        end
        set_in(1'b0, 5'd3, 32'd0, 1'b1, 5'd4, 32'h403);
        #2;
        total++;
        if (p_a_ready !== 1'b0 || p_b_ready !== 1'b1) begin
            bad++; $display("FAIL fixed_b_after got a=%b b=%b exp a=0 b=1", p_a_ready, p_b_ready);
        end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if (p_wr_en !== 1'b1 || p_wr_addr !== 5'd4 || p_wr_data !== 32'h403) begin
            bad++; $display("FAIL fixed_b_write got en=%b addr=%0d data=%h exp en=1 addr=4 data=403",
                            p_wr_en, p_wr_addr, p_wr_data);
        end
        advance();
    endtask

    task automatic test_x0();
        do_reset();
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678);
        #2;
        total++;
        if (f_b_ready !== 1'b1 || p_b_ready !== 1'b1) begin
            bad++; $display("FAIL x0_ready got=%b%b exp=11", f_b_ready, p_b_ready);
        end
        advance();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++;
        if (f_wr_en !== 1'b0 || f_wr_sel !== 32'd0 || f_wr_data !== 32'h12345678 || f_wr_addr !== 5'd0) begin
            bad++; $display("FAIL x0_write got en=%b sel=%h addr=%0d data=%h exp en=0 sel=0 addr=0 data=12345678",
                            f_wr_en, f_wr_sel, f_wr_addr, f_wr_data);
        end
        advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
`ifdef RF_SCRUB_EN
        rst = 1'b1;
        advance();
        rst = 1'b0;
        model_eval();
        repeat (10) advance();
        total++;
        if (f_wr_addr !== 5'd10 || f_wr_en !== 1'b1) begin
            bad++; $display("FAIL mid_scrub_pos got en=%b addr=%0d exp en=1 addr=10", f_wr_en, f_wr_addr);
        end
        rst = 1'b1;
        advance();
        total++;
        if (f_wr_en !== 1'b0 || f_wr_sel !== 32'd0) begin
            bad++; $display("FAIL mid_scrub_rst got en=%b sel=%h exp en=0 sel=0", f_wr_en, f_wr_sel);
        end
        rst = 1'b0;
        model_eval();
        advance();
        total++;
        if (f_wr_en !== 1'b1 || f_wr_addr !== 5'd1 || f_wr_sel !== 32'h2) begin
            bad++; $display("FAIL scrub_restart got en=%b addr=%0d sel=%h exp en=1 addr=1 sel=00000002",
                            f_wr_en, f_wr_addr, f_wr_sel);
        end
        repeat (30) advance();
`else
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(i + 20), 32'h5000 + 32'(i), 1'b0, 5'd0, 32'd0);
            advance();
        end
        // last grant was A: without reset a tie would now go to B
        rst = 1'b1;
        set_in(1'b1, 5'd22, 32'h6000, 1'b1, 5'd23, 32'h7000);
        advance();
        total++;
        if (f_wr_en !== 1'b0 || f_wr_sel !== 32'd0) begin
            bad++; $display("FAIL mid_stream_rst got en=%b sel=%h exp en=0 sel=0", f_wr_en, f_wr_sel);
        end
        rst = 1'b0;
        model_eval();
        #2;
        total++;
        if (f_a_ready !== 1'b1 || f_b_ready !== 1'b0) begin
            bad++; $display("FAIL rst_prio_a got a=%b b=%b exp a=1 b=0", f_a_ready, f_b_ready);
        end
        advance();
        total++;
        if (f_wr_en !== 1'b1 || f_wr_addr !== 5'd22) begin
            bad++; $display("FAIL rst_first_write got en=%b addr=%0d exp en=1 addr=22", f_wr_en, f_wr_addr);
        end
`endif
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        advance();
    endtask

    task automatic test_random();
        logic [4:0] aa, ba;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            aa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ba = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            set_in(1'($urandom_range(0, 3) != 0), aa, $urandom(),
                   1'($urandom_range(0, 3) != 0), ba, $urandom());
            #2;
            total++;
            if ({f_a_ready, f_b_ready, f_busy, p_a_ready, p_b_ready, p_busy} !==
                {m_ga[0], m_gb[0], m_busy, m_ga[1], m_gb[1], m_busy}) begin
                bad++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c,
                                {f_a_ready, f_b_ready, f_busy, p_a_ready, p_b_ready, p_busy},
                                {m_ga[0], m_gb[0], m_busy, m_ga[1], m_gb[1], m_busy});
            end
            advance();
            total++;
            if ({f_wr_en, f_wr_addr, f_wr_data, f_wr_sel} !== {m_en[0], m_addr[0], m_data[0], m_sel[0]}) begin
                bad++; $display("FAIL rnd_write_fair c=%0d got=%h exp=%h", c,
                                {f_wr_en, f_wr_addr, f_wr_data, f_wr_sel}, {m_en[0], m_addr[0], m_data[0], m_sel[0]});
            end
            total++;
            if ({p_wr_en, p_wr_addr, p_wr_data, p_wr_sel} !== {m_en[1], m_addr[1], m_data[1], m_sel[1]}) begin
                bad++; $display("FAIL rnd_write_fixed c=%0d got=%h exp=%h", c,
                                {p_wr_en, p_wr_addr, p_wr_data, p_wr_sel}, {m_en[1], m_addr[1], m_data[1], m_sel[1]});
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef RF_SCRUB_EN
        test_scrub();
`endif
        test_single_a();
        test_fair_alternate();
        test_fixed_priority();
        test_x0();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/_rf_wr_sched.md
Name: _rf_wr_sched

Overview:
- Write-port scheduler for the 32-entry register file.
- Arbitrates two writeback requesters (A: ALU path, B: load path) onto the single write port.
- Registers the winning address and data, and drives the one-hot register write-select that the 5-to-32 decode produces.
- Optionally sequences a post-reset scrub that zeroes every register.

Parameters:
XLEN, 32, data width of write data.
FAIR, 1, 1 = round-robin between A and B; 0 = fixed priority, A always wins.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
a_valid  in  1  requester A has a write pending.
a_ready  out  1  A accepted this cycle.
a_addr  in  5  A destination register.
a_data  in  XLEN  A write data.
b_valid  in  1  requester B has a write pending.
b_ready  out  1  B accepted this cycle.
b_addr  in  5  B destination register.
b_data  in  XLEN  B write data.
wr_en  out  1  register-file write strobe.
wr_addr  out  5  register index being written.
wr_data  out  XLEN  data being written.
wr_sel  out  32  one-hot decode of wr_addr, gated by wr_en (all zero when wr_en=0).
busy  out  1  scrub in progress; requesters must not expect acceptance.

Behaviour:
- Reset (rst=1 at an edge):
  - wr_en=0, wr_addr=0, wr_data=0, wr_sel=0.
  - Round-robin pointer set so A has priority next.
  - busy=1 if RF_SCRUB_EN is defined, else busy=0.
  - State <= SCRUB if RF_SCRUB_EN, else RUN; scrub counter <= 1.
- States: SCRUB, RUN. No other states.
- SCRUB:
  - Each cycle: wr_en=1, wr_addr=counter, wr_data=0, wr_sel=decode(counter); counter increments.
  - Covers registers 1..31, so 31 write cycles. After the cycle writing 31, next state is RUN and busy=0.
  - a_ready=b_ready=0 throughout.
- RUN, grant (combinational):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid, FAIR=1: grant the requester not granted most recently; the pointer updates only on an accepted grant.
  - Both valid, FAIR=0: A wins.
  - Never both readies high in the same cycle. ready may depend combinationally on valid.
- Accept: the transfer is (x_valid && x_ready) at a clock edge. Output registers load on that edge, so latency is 1 cycle from accept to wr_en.
  - wr_addr/wr_data load the granted address and data.
  - wr_en=1 unless addr==0. Writes to x0 are accepted (ready=1) but produce wr_en=0 and wr_sel=0.
  - wr_addr/wr_data still load on an x0 write.
- Idle: no accept in a RUN cycle gives wr_en=0 and wr_sel=0 next cycle. wr_addr/wr_data hold their last values.
- Throughput: one write per cycle, sustainable back-to-back, no bubbles.
- Same-address hazards between A and B are not checked; the later-accepted write wins in the register file.
- Reset mid-scrub or mid-stream:
  - Any pending output is dropped: wr_en=0 on the cycle after the rst edge.
  - Scrub restarts at register 1.
- wr_sel always equals one-hot(wr_addr) & {32{wr_en}}. It is registered with wr_addr, not decoded after the register.

Optional Feature:
RF_SCRUB_EN:
- Defined: SCRUB state exists. After reset, busy=1 for 31 cycles while registers 1..31 are written with 0, then RUN.
- Undefined: the SCRUB state and scrub counter are not built. busy is tied to 0. RUN is entered directly after reset, so the first accept is possible in the first cycle after rst deasserts.

Test Plan:
1. RF_SCRUB_EN defined; release rst -> wr_addr steps 1,2,...,31 on consecutive cycles with wr_data=0 and wr_sel=1<<n; busy falls after the addr-31 cycle; a_valid held high is first accepted only after that.
2. RUN, a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, wr_sel=0x00000020.
3. FAIR=1, A and B both valid for 4 cycles -> grants alternate A,B,A,B; never both readies high; wr_en high on all 4 following cycles.
4. FAIR=0, A and B both valid for 3 cycles -> only a_ready is high; b_ready is high on the first cycle after a_valid drops.
5. b_valid=1, b_addr=0, b_data=0x12345678 -> b_ready=1; next cycle wr_en=0, wr_sel=0.
6. Assert rst during scrub at counter=10 (or during an A stream) -> wr_en=0 next cycle; scrub restarts at register 1 (or, without RF_SCRUB_EN, RUN with A priority).
